// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if
// Groups the FIFO read port and the downstream valid/ready stream used by
// fifo_burst_reader.
//   fifo_rd_en      read request to the FIFO
//   fifo_dout       FIFO registered read data (valid the cycle after rd_en)
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   m_valid/m_data  output word and its valid
//   m_ready         downstream accept
// master: the burst reader's view; slave: the FIFO/consumer side.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        output m_valid,
        output m_data,
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_underflow,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        output fifo_dout,
        output fifo_empty,
        output fifo_underflow,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-side master for the project FIFO. On a start command it drains exactly
// burst_len words from the FIFO, buffers them in a small circular buffer and
// forwards them in order on a valid/ready stream, then pulses done.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           1-cycle command, only honoured in IDLE
//   burst_len       words to drain, sampled with start (0 = ignored)
//   bus (master)    FIFO read port and output stream
//   busy            burst in progress (READ, FLUSH, DONE)
//   done            1-cycle pulse at burst completion
//   rd_count        words read from the FIFO in the current/last burst
//   err, err_cnt    sticky underflow flag and saturating underflow cycle count
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int ERR_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    fifo_burst_reader_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     rd_count,
    output logic                 err,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef logic [OCC_W:0] inflight_t;
    localparam inflight_t DEPTH_L = inflight_t'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      rd_count_q, rd_count_d;
    logic [LEN_W-1:0]      sent_q, sent_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  err_q, err_d;
    logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;

    logic                  accept_s;
    logic                  rd_en_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  m_valid_s;
    inflight_t             inflight_s;

    // Handshake qualifiers. A read is only issued when the word it returns is
    // guaranteed a buffer slot: words already in the buffer plus the one still
    // in flight from last cycle must leave room.
    always_comb begin
        accept_s   = (state_q == ST_IDLE) && start && (burst_len != {LEN_W{1'b0}});
        inflight_s = {1'b0, occ_q} + {{OCC_W{1'b0}}, pending_q};
        rd_en_s    = (state_q == ST_READ) && !bus.fifo_empty &&
                     (rd_count_q < len_q) && (inflight_s < DEPTH_L);
        m_valid_s  = (occ_q != {OCC_W{1'b0}});
        push_s     = pending_q;
        pop_s      = m_valid_s && bus.m_ready;
    end

    // Burst sequencing: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_READ;
                else          state_d = ST_IDLE;
            end
            ST_READ: begin
                if (rd_count_q == len_q) state_d = ST_FLUSH;
                else                     state_d = ST_READ;
            end
            ST_FLUSH: begin
                if (sent_q == len_q) state_d = ST_DONE;
                else                 state_d = ST_FLUSH;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: counters, buffer, pointers, error tracking.
    always_comb begin
        len_d      = len_q;
        rd_count_d = rd_count_q;
        sent_d     = sent_q;
        pending_d  = rd_en_s;
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        if (accept_s) begin
            len_d      = burst_len;
            rd_count_d = {LEN_W{1'b0}};
            sent_d     = {LEN_W{1'b0}};
        end else begin
            if (rd_en_s) rd_count_d = rd_count_q + LEN_W'(1);
            else         rd_count_d = rd_count_q;
            if (pop_s)   sent_d = sent_q + LEN_W'(1);
            else         sent_d = sent_q;
        end

        // FIFO data is registered, so the word requested last cycle lands now.
        if (push_s) begin
            buf_d[wr_ptr_q] = bus.fifo_dout;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else       rd_ptr_d = rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (bus.fifo_underflow) begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
            else                            err_cnt_d = err_cnt_q;
        end else begin
            err_d     = err_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // Burst sequencing: state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers. Clearing pending_q drops any word returning from a
    // read issued before reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= {LEN_W{1'b0}};
            rd_count_q <= {LEN_W{1'b0}};
            sent_q     <= {LEN_W{1'b0}};
            pending_q  <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            occ_q      <= {OCC_W{1'b0}};
            err_q      <= 1'b0;
            err_cnt_q  <= {ERR_W{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= {DATA_WIDTH{1'b0}};
        end else begin
            len_q      <= len_d;
            rd_count_q <= rd_count_d;
            sent_q     <= sent_d;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= buf_d[i];
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = m_valid_s;
    assign bus.m_data     = buf_q[rd_ptr_q];
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign rd_count       = rd_count_q;
    assign err            = err_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO with registered read data,
// a transaction-level reference model evaluated every cycle, directed
// scenarios with literal expectations, then randomized bursts.
module tb_fifo_burst_reader;
    localparam int DW   = 16;
    localparam int LW   = 8;
    localparam int BD   = 4;
    localparam int EW   = 4;
    localparam int EMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic [LW-1:0] rd_count;
    logic          err;
    logic [EW-1:0] err_cnt;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_W(LW), .BUF_DEPTH(BD), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .bus(bus),
        .busy(busy), .done(done), .rd_count(rd_count), .err(err), .err_cnt(err_cnt)
    );

    // FIFO with registered read data
    logic [DW-1:0] fifo_q[$];
    logic          push_req = 1'b0;
    logic [DW-1:0] push_data = '0;

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
        if (push_req) fifo_q.push_back(push_data);
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    // Reference model state
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            armed = 1'b0;
    bit            resync = 1'b0;
    bit            after_rst = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] hs_log[$];
    int            cap_m = 0, sent_tot = 0, rd_tot = 0;
    int            reads_burst = 0, sent_burst = 0, len_m = 0;
    bit            busy_m = 1'b0;
    int            done_at = -1;
    bit            h1 = 1'b0, h2 = 1'b0;
    bit            err_m = 1'b0;
    int            errcnt_m = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            rd_en_cnt = 0, done_cnt = 0;

    logic          s_rd_en, s_valid, s_done, s_busy, s_err;
    logic [DW-1:0] s_data;
    logic [LW-1:0] s_rd_count;
    logic [EW-1:0] s_err_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: sample at negedge, compare with the model, advance it.
    task automatic step();
        bit hs;
        bit idle_now;
        @(negedge clk);
        s_rd_en = bus.fifo_rd_en; s_valid = bus.m_valid; s_data = bus.m_data;
        s_done = done; s_busy = busy; s_rd_count = rd_count;
        s_err = err; s_err_cnt = err_cnt;
        cyc++;
        if (rst) begin
            cap_m = 0; sent_tot = 0; rd_tot = 0; reads_burst = 0; sent_burst = 0; len_m = 0;
            busy_m = 1'b0; done_at = -1; h1 = 1'b0; h2 = 1'b0;
            err_m = 1'b0; errcnt_m = 0; prev_stall = 1'b0;
            exp_q.delete();
            resync = 1'b1; armed = 1'b1; after_rst = 1'b1;
        end else if (armed) begin
            // words read before reset are lost: expect what is still in the FIFO
            if (resync) begin exp_q = fifo_q; resync = 1'b0; end
            cap_m += int'(h2);
            if (after_rst) begin
                chk("reset_m_data", 64'(s_data), 64'd0);
                after_rst = 1'b0;
            end
            chk("m_valid", 64'(s_valid), 64'((cap_m - sent_tot) > 0));
            chk("busy", 64'(s_busy), 64'(busy_m));
            chk("done", 64'(s_done), 64'(cyc == done_at));
            chk("rd_count", 64'(s_rd_count), 64'(reads_burst));
            chk("err", 64'(s_err), 64'(err_m));
            chk("err_cnt", 64'(s_err_cnt), 64'(errcnt_m));
            if (prev_stall) chk("hold_m_data", 64'(s_data), 64'(prev_data));
            if (s_rd_en) begin
                chk("rd_en_while_empty", 64'(bus.fifo_empty), 64'd0);
                chk("rd_en_in_burst", 64'(busy_m && reads_burst < len_m), 64'd1);
                chk("rd_en_buffer_room", 64'((rd_tot - sent_tot) < BD), 64'd1);
            end
            idle_now = !busy_m;
            hs = s_valid && bus.m_ready;
            if (hs) begin
                chk("hs_word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("hs_data", 64'(s_data), 64'(exp_q.pop_front()));
                hs_log.push_back(s_data);
                sent_tot++; sent_burst++;
                chk("sent_le_len", 64'(sent_burst <= len_m), 64'd1);
                if (sent_burst == len_m) done_at = cyc + 2;
            end
            prev_stall = s_valid && !bus.m_ready;
            prev_data  = s_data;
            if (s_rd_en) begin reads_burst++; rd_tot++; rd_en_cnt++; end
            h2 = h1; h1 = s_rd_en;
            if (s_done) done_cnt++;
            if (cyc == done_at) busy_m = 1'b0;
            if (idle_now && start && burst_len != 0) begin
                busy_m = 1'b1; len_m = int'(burst_len); reads_burst = 0; sent_burst = 0;
            end
            if (bus.fifo_underflow) begin
                err_m = 1'b1;
                if (errcnt_m < EMAX) errcnt_m++;
            end
            if (push_req) exp_q.push_back(push_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_req = 1'b1; push_data = base + DW'(i);
            step();
        end
        push_req = 1'b0;
        step();
    endtask

    task automatic launch(input int len);
        burst_len = LW'(len); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin step(); n++; end
        chk({name, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    endtask

    initial begin
        int first_rd, last_rd, first_v, n, left, len;
        rst = 1'b1; start = 1'b0; burst_len = '0;
        bus.m_ready = 1'b0; bus.fifo_underflow = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // 1: five preloaded words, consumer always ready
        push_words(16'hA000, 5);
        bus.m_ready = 1'b1; rd_en_cnt = 0; done_cnt = 0; hs_log.delete();
        launch(5);
        n = 0; first_rd = -1; last_rd = -1; first_v = -1;
        while (done_cnt == 0 && n < 40) begin
            step(); n++;
            if (s_rd_en) begin if (first_rd < 0) first_rd = n; last_rd = n; end
            if (s_valid && first_v < 0) first_v = n;
        end
        chk("t1_done_seen", 64'(done_cnt), 64'd1);
        chk("t1_rd_en_cycles", 64'(rd_en_cnt), 64'd5);
        chk("t1_rd_en_back_to_back", 64'(last_rd - first_rd), 64'd4);
        chk("t1_first_valid_latency", 64'(first_v - first_rd), 64'd2);
        chk("t1_words", 64'(hs_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < hs_log.size(); i++)
            chk("t1_word_order", 64'(hs_log[i]), 64'(16'hA000 + 16'(i)));
        step(); step();
        chk("t1_single_done", 64'(done_cnt), 64'd1);
        chk("t1_rd_count", 64'(s_rd_count), 64'd5);

        // 2: full FIFO, consumer stalled
        push_words(16'hB000, 8);
        bus.m_ready = 1'b0; rd_en_cnt = 0; done_cnt = 0; hs_log.delete();
        launch(8);
        for (int i = 0; i < 12; i++) step();
        chk("t2_rd_en_stalled", 64'(rd_en_cnt), 64'd4);
        chk("t2_valid_stalled", 64'(s_valid), 64'd1);
        chk("t2_head_word", 64'(s_data), 64'(16'hB000));
        bus.m_ready = 1'b1;
        run_until_done(60, "t2");
        chk("t2_words", 64'(hs_log.size()), 64'd8);
        if (hs_log.size() == 8) chk("t2_last_word", 64'(hs_log[7]), 64'(16'hB007));
        step();

        // 3: empty FIFO, words trickle in
        rd_en_cnt = 0; done_cnt = 0; hs_log.delete();
        launch(3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_busy_waiting", 64'(s_busy), 64'd1);
            chk("t3_no_rd_when_empty", 64'(s_rd_en), 64'd0);
        end
        for (int w = 0; w < 3; w++) begin
            push_req = 1'b1; push_data = 16'hC000 + 16'(w);
            step();
            push_req = 1'b0;
            for (int i = 0; i < 4; i++) step();
        end
        run_until_done(30, "t3");
        chk("t3_rd_en_cycles", 64'(rd_en_cnt), 64'd3);
        chk("t3_words", 64'(hs_log.size()), 64'd3);
        step();

        // 4: zero-length start, then start during an active burst
        done_cnt = 0;
        launch(0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_len0_idle", 64'(s_busy), 64'd0);
        end
        chk("t4_len0_no_done", 64'(done_cnt), 64'd0);
        push_words(16'hD000, 6);
        bus.m_ready = 1'b0; hs_log.delete();
        launch(2);
        for (int i = 0; i < 3; i++) step();
        launch(4);
        bus.m_ready = 1'b1;
        run_until_done(40, "t4");
        for (int i = 0; i < 4; i++) step();
        chk("t4_words", 64'(hs_log.size()), 64'd2);
        chk("t4_rd_count", 64'(s_rd_count), 64'd2);
        chk("t4_single_done", 64'(done_cnt), 64'd1);
        chk("t4_back_to_idle", 64'(s_busy), 64'd0);
        done_cnt = 0; hs_log.delete();
        launch(4);
        run_until_done(40, "t4_drain");
        if (hs_log.size() == 4) chk("t4_drain_last", 64'(hs_log[3]), 64'(16'hD005));
        step();

        // 5: reset in the middle of a burst
        push_words(16'hE000, 6);
        done_cnt = 0; hs_log.delete();
        launch(6);
        n = 0;
        while (hs_log.size() < 2 && n < 30) begin step(); n++; end
        chk("t5_two_handshakes", 64'(hs_log.size()), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t5_valid_cleared", 64'(s_valid), 64'd0);
        chk("t5_busy_cleared", 64'(s_busy), 64'd0);
        chk("t5_rd_en_cleared", 64'(s_rd_en), 64'd0);
        chk("t5_rd_count_cleared", 64'(s_rd_count), 64'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        left = fifo_q.size();
        if (left < 2) push_words(16'hE100, 2 - left);
        hs_log.delete();
        launch(2);
        run_until_done(40, "t5_restart");
        chk("t5_restart_words", 64'(hs_log.size()), 64'd2);
        step();
        left = fifo_q.size();
        if (left > 0) begin
            done_cnt = 0;
            launch(left);
            run_until_done(60, "t5_drain");
            step();
        end

        // 6: underflow counting and saturation
        bus.fifo_underflow = 1'b1;
        step();
        step();
        chk("t6_err_after_first", 64'(s_err), 64'd1);
        step();
        bus.fifo_underflow = 1'b0;
        step();
        chk("t6_err_cnt_3", 64'(s_err_cnt), 64'd3);
        bus.fifo_underflow = 1'b1;
        for (int i = 0; i < 20; i++) step();
        bus.fifo_underflow = 1'b0;
        step();
        chk("t6_err_cnt_sat", 64'(s_err_cnt), 64'd15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_err_cleared", 64'(s_err), 64'd0);
        chk("t6_err_cnt_cleared", 64'(s_err_cnt), 64'd0);

        // randomized bursts: random lengths, pushes, back-pressure, underflow
        for (int b = 0; b < 12; b++) begin
            len = int'($urandom_range(1, 12));
            done_cnt = 0;
            launch(len);
            n = 0;
            while (done_cnt == 0 && n < 400) begin
                bus.m_ready = 1'($urandom_range(0, 1));
                bus.fifo_underflow = ($urandom_range(0, 15) == 0);
                push_req = (fifo_q.size() < 8) && ($urandom_range(0, 1) == 1);
                push_data = 16'($urandom);
                step(); n++;
            end
            push_req = 1'b0; bus.fifo_underflow = 1'b0;
            chk("rand_done_seen", 64'(done_cnt), 64'd1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the project FIFO: drives rd_en, watches empty/underflow, captures data_out and forwards words on a valid/ready stream.
- On a start command it drains exactly burst_len words, then pulses done.
- Sits between the FIFO DUT read port and any downstream consumer, including the UVM scoreboard-side driver.
- The FIFO has registered read data: data_out is valid the cycle after rd_en is sampled.

Parameters:
DATA_WIDTH, 16, word width; matches FIFO_WIDTH.
LEN_W, 8, width of burst_len and of the word counters.
BUF_DEPTH, 4, output buffer entries; power of 2, >=2.
ERR_W, 4, width of the saturating underflow error counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  1-cycle command pulse; sampled only in IDLE.
burst_len  in  LEN_W  number of words to drain; sampled with start.
fifo_rd_en  out  1  read request to FIFO.
fifo_dout  in  DATA_WIDTH  FIFO data_out.
fifo_empty  in  1  FIFO empty flag.
fifo_underflow  in  1  FIFO underflow flag.
m_valid  out  1  output word valid.
m_data  out  DATA_WIDTH  output word.
m_ready  in  1  downstream accept.
busy  out  1  burst in progress, IDLE excluded.
done  out  1  1-cycle pulse at burst completion.
rd_count  out  LEN_W  words read from the FIFO in the current or last burst.
err  out  1  sticky underflow seen.
err_cnt  out  ERR_W  saturating count of cycles with fifo_underflow=1.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0, err=0, err_cnt=0.
  - Buffer emptied; pending-read flag cleared. FIFO data returning the cycle after reset is discarded.
- State machine: IDLE, READ, FLUSH, DONE.
  - IDLE: start=1 and burst_len!=0 -> latch len, clear rd_count and sent count, go to READ. start with burst_len=0 is ignored (stay IDLE, no done).
  - READ: when rd_count==len, go to FLUSH.
  - FLUSH: when sent==len, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - busy=1 in READ, FLUSH and DONE.
  - start outside IDLE is ignored.
- fifo_rd_en is combinational and equals 1 only when all of the following hold: state==READ, fifo_empty==0, rd_count<len, and pending+occupancy<BUF_DEPTH.
  - pending is 1 if rd_en was high in the previous cycle.
  - fifo_rd_en is never asserted while fifo_empty=1.
  - rd_count increments on every cycle rd_en=1.
- Capture: when pending=1, fifo_dout is written into the buffer tail at that edge.
  - Latency: first m_valid occurs 2 cycles after the first rd_en cycle.
- Output: m_valid = (occupancy!=0); m_data = buffer head.
  - A handshake (m_valid&&m_ready) pops the head and increments sent.
  - While m_valid=1 and m_ready=0, m_data is held stable.
  - Word order matches FIFO order.
  - Capture and pop in the same cycle leave occupancy unchanged.
- Throughput: with m_ready=1 and the FIFO non-empty, one word per cycle sustained.
- Back-pressure: m_ready=0 holds the buffer. At most BUF_DEPTH words are read before rd_en stops.
- Error handling: any cycle with fifo_underflow=1 sets err and increments err_cnt, saturating at 2^ERR_W-1. Both clear only on rst.
- Counters: rd_count and sent never exceed len.
- Reset mid-burst: abandons the burst; no done pulse. Words already read from the FIFO are lost (documented behaviour).

Test Plan:
1. FIFO preloaded 0xA000..0xA004, start with burst_len=5, m_ready=1 -> rd_en high 5 consecutive cycles; m_data 0xA000..0xA004 in order; first m_valid 2 cycles after first rd_en; done pulses once after the 5th handshake; rd_count=5.
2. FIFO full (8 words), burst_len=8, m_ready=0 -> exactly 4 rd_en cycles, then rd_en=0; m_valid=1 with m_data equal to the first word, held stable. Raise m_ready -> all 8 words delivered in order, done=1.
3. FIFO empty, burst_len=3 -> busy=1, rd_en=0 while empty. Push 3 words 5 cycles apart -> each read only when empty=0; done after the 3rd handshake.
4. start with burst_len=0 -> stays IDLE, busy=0, no done. start pulse during an active burst with burst_len=4 -> ignored; the first burst completes with its own length.
5. burst_len=6, rst pulsed after the 2nd handshake -> next cycle m_valid=0, busy=0, rd_en=0, rd_count=0, no done. New start with burst_len=2 completes normally.
6. Force fifo_underflow=1 for 3 cycles, then for 20 cycles -> err=1 after the first; err_cnt=3, then saturates at 15; both cleared by rst.
